// File: rtl/pulse_train_pkg.sv
// pulse_train_pkg: shared types and defaults
// for the pulse train generator.
package pulse_train_pkg;

    localparam int SYNC_STAGES = 2;
    localparam int DEF_DW      = 16;
    localparam int DEF_CW      = 32;
    localparam int DEF_NW      = 16;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        HIGH,
        LOW
    } state_t;

endpackage

// File: rtl/trig_edge_sync.sv
// trig_edge_sync: optional N-stage synchronizer
// followed by a registered rising-edge detect.
module trig_edge_sync
    import pulse_train_pkg::*;
#(
    parameter int STAGES = SYNC_STAGES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);

    logic s;
    logic prev;

    generate
        if (STAGES == 0) begin : g_direct
            assign s = din;
        end else begin : g_sync
            logic [STAGES-1:0] sync;

            // shift the raw input through the synchronizer chain
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync <= '0;
                end else begin
                    sync[0] <= din;
                    for (int i = 1; i < STAGES; i++) begin
                        sync[i] <= sync[i-1];
                    end
                end
            end

            assign s = sync[STAGES-1];
        end
    endgenerate

    // one-cycle strobe on each low-to-high transition of s
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev <= 1'b0;
            rise <= 1'b0;
        end else begin
            prev <= s;
            rise <= s & ~prev;
        end
    end

endmodule

// File: rtl/pulse_train_gen.sv
// pulse_train_gen: trigger-launched train of
// rectangular pulses driving a signed DAC sample.
module pulse_train_gen
    import pulse_train_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int CW = DEF_CW,
    parameter int NW = DEF_NW
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Enable,
    input  logic                 SwTrig,
    input  logic                 ExtTrig,
    input  logic                 ExtTrigEn,
    input  logic signed [DW-1:0] Amplitude,
    input  logic signed [DW-1:0] Baseline,
    input  logic        [CW-1:0] DelayCycles,
    input  logic        [CW-1:0] HighCycles,
    input  logic        [CW-1:0] LowCycles,
    input  logic        [NW-1:0] PulseCount,
    output logic signed [DW-1:0] Dout,
    output logic                 Busy,
    output logic        [NW-1:0] PulseIdx,
    output logic                 Done
);

    logic ext_rise;
    logic sw_rise;
    logic trig;

    logic [CW-1:0] high_in;
    logic [CW-1:0] low_in;

    state_t               state;
    logic        [CW-1:0] cnt;
    logic signed [DW-1:0] amp_q;
    logic signed [DW-1:0] base_q;
    logic        [CW-1:0] high_q;
    logic        [CW-1:0] low_q;
    logic        [NW-1:0] count_q;
    logic                 last_pulse;

    trig_edge_sync #(
        .STAGES (SYNC_STAGES)
    ) u_ext (
        .clk   (Clk),
        .rst_n (Reset),
        .din   (ExtTrig),
        .rise  (ext_rise)
    );

    trig_edge_sync #(
        .STAGES (0)
    ) u_sw (
        .clk   (Clk),
        .rst_n (Reset),
        .din   (SwTrig),
        .rise  (sw_rise)
    );

    assign trig = Enable & (sw_rise | (ExtTrigEn & ext_rise));

    assign high_in = (HighCycles == '0) ? CW'(1) : HighCycles;
    assign low_in  = (LowCycles  == '0) ? CW'(1) : LowCycles;

    assign last_pulse = (count_q != '0) &&
                        (PulseIdx == count_q - NW'(1));

    // phase sequencer; outputs registered from the next state
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state    <= IDLE;
            cnt      <= '0;
            amp_q    <= '0;
            base_q   <= '0;
            high_q   <= CW'(1);
            low_q    <= CW'(1);
            count_q  <= '0;
            Dout     <= '0;
            Busy     <= 1'b0;
            PulseIdx <= '0;
            Done     <= 1'b0;
        end else begin
            Done <= 1'b0;
            if (!Enable) begin
                state <= IDLE;
                Dout  <= base_q;
                Busy  <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (trig) begin
                            amp_q    <= Amplitude;
                            base_q   <= Baseline;
                            high_q   <= high_in;
                            low_q    <= low_in;
                            count_q  <= PulseCount;
                            PulseIdx <= '0;
                            Busy     <= 1'b1;
                            if (DelayCycles != '0) begin
                                state <= DELAY;
                                cnt   <= DelayCycles;
                                Dout  <= Baseline;
                            end else begin
                                state <= HIGH;
                                cnt   <= high_in;
                                Dout  <= Amplitude;
                            end
                        end
                    end
                    DELAY: begin
                        if (cnt == CW'(1)) begin
                            state <= HIGH;
                            cnt   <= high_q;
                            Dout  <= amp_q;
                        end else begin
                            cnt <= cnt - CW'(1);
                        end
                    end
                    HIGH: begin
                        if (cnt == CW'(1)) begin
                            Dout <= base_q;
                            if (last_pulse) begin
                                state <= IDLE;
                                Busy  <= 1'b0;
                                Done  <= 1'b1;
                            end else begin
                                state <= LOW;
                                cnt   <= low_q;
                            end
                        end else begin
                            cnt <= cnt - CW'(1);
                        end
                    end
                    LOW: begin
                        if (cnt == CW'(1)) begin
                            state    <= HIGH;
                            cnt      <= high_q;
                            Dout     <= amp_q;
                            PulseIdx <= PulseIdx + NW'(1);
                        end else begin
                            cnt <= cnt - CW'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                        Busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pulse_train_gen.sv
// tb_pulse_train_gen: table-driven, hand-written
// and randomized checks of the pulse train generator.
module tb_pulse_train_gen;

    logic               Clk = 1'b0;
    logic               Reset;
    logic               Enable;
    logic               SwTrig;
    logic               ExtTrig;
    logic               ExtTrigEn;
    logic signed [15:0] Amplitude;
    logic signed [15:0] Baseline;
    logic        [31:0] DelayCycles;
    logic        [31:0] HighCycles;
    logic        [31:0] LowCycles;
    logic        [15:0] PulseCount;
    logic signed [15:0] Dout;
    logic               Busy;
    logic        [15:0] PulseIdx;
    logic               Done;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int prev_base = 0;
    int prev_idx  = 0;

    typedef struct {
        int amp;
        int base;
        int d;
        int h;
        int l;
        int n;
        bit ext;
        bit dis;
        int exp_first;
        int exp_done;
    } vec_t;

    vec_t vecs[5];

    pulse_train_gen dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Enable      (Enable),
        .SwTrig      (SwTrig),
        .ExtTrig     (ExtTrig),
        .ExtTrigEn   (ExtTrigEn),
        .Amplitude   (Amplitude),
        .Baseline    (Baseline),
        .DelayCycles (DelayCycles),
        .HighCycles  (HighCycles),
        .LowCycles   (LowCycles),
        .PulseCount  (PulseCount),
        .Dout        (Dout),
        .Busy        (Busy),
        .PulseIdx    (PulseIdx),
        .Done        (Done)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string nm,
                       input int act,
                       input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s @%0d: got %0d expected %0d",
                     nm, cyc, act, exp);
        end
    endtask

    // Reference: the waveform as a function of the offset
    // from the first busy cycle, from the train's timing rules.
    task automatic run_train(input int amp, input int base,
                             input int d, input int h,
                             input int l, input int n,
                             input bit ext, input bit dis,
                             output int first, output int donec);
        int c0, lat, hp, lp, per, len, off, j;
        int e_dout, e_busy, e_done, e_idx;
        first = -1;
        donec = -1;
        Amplitude   = 16'(amp);
        Baseline    = 16'(base);
        DelayCycles = 32'(d);
        HighCycles  = 32'(h);
        LowCycles   = 32'(l);
        PulseCount  = 16'(n);
        ExtTrigEn   = ext;
        c0 = cyc;
        if (ext) ExtTrig = 1'b1;
        else     SwTrig  = 1'b1;
        lat = ext ? 4 : 2;
        hp  = (h == 0) ? 1 : h;
        lp  = (l == 0) ? 1 : l;
        per = hp + lp;
        len = d + n * per - lp;
        for (int k = 1; k <= lat + len + 3; k++) begin
            tick();
            off = k - lat;
            e_done = 0;
            if (off < 0) begin
                e_dout = prev_base;
                e_busy = 0;
                e_idx  = prev_idx;
            end else if (off < d) begin
                e_dout = base;
                e_busy = 1;
                e_idx  = 0;
            end else begin
                j = off - d;
                if (j >= n * per - lp) begin
                    e_dout = base;
                    e_busy = 0;
                    e_done = (j == n * per - lp) ? 1 : 0;
                    e_idx  = n - 1;
                end else begin
                    e_dout = (j % per < hp) ? amp : base;
                    e_busy = 1;
                    e_idx  = j / per;
                end
            end
            chk("dout", int'(Dout), e_dout);
            chk("busy", int'(Busy), e_busy);
            chk("done", int'(Done), e_done);
            chk("idx", int'(PulseIdx), e_idx);
            if (first < 0 && int'(Dout) == amp)
                first = k;
            if (donec < 0 && Done)
                donec = k;
            if (k == 1) begin
                SwTrig  = 1'b0;
                ExtTrig = 1'b0;
            end
            if (dis && off >= 1 && off <= len - 4) begin
                SwTrig    = 1'($urandom_range(0, 1));
                Amplitude = 16'($urandom_range(0, 4000));
            end
            if (off == len - 3)
                SwTrig = 1'b0;
        end
        SwTrig    = 1'b0;
        prev_base = base;
        prev_idx  = n - 1;
    endtask

    initial begin
        int first, donec, c0, amp, base;
        bit seen;

        vecs[0] = '{1000, -200, 0, 3, 2, 3, 0, 1, 2, 15};
        vecs[1] = '{-300, 50, 5, 2, 1, 2, 1, 0, 9, 14};
        vecs[2] = '{123, -7, 0, 0, 0, 4, 0, 1, 2, 9};
        vecs[3] = '{-32768, 32767, 3, 1, 4, 1, 0, 0, 5, 6};
        vecs[4] = '{2222, 0, 0, 4, 0, 2, 1, 1, 4, 13};

        Reset = 1'b0;
        Enable = 1'b0;
        SwTrig = 1'b0;
        ExtTrig = 1'b0;
        ExtTrigEn = 1'b0;
        Amplitude = '0;
        Baseline = '0;
        DelayCycles = '0;
        HighCycles = '0;
        LowCycles = '0;
        PulseCount = '0;
        repeat (3) tick();
        Reset = 1'b1;
        tick();
        chk("rst_dout", int'(Dout), 0);
        chk("rst_busy", int'(Busy), 0);
        chk("rst_done", int'(Done), 0);
        chk("rst_idx", int'(PulseIdx), 0);
        Enable = 1'b1;
        repeat (2) tick();

        for (int v = 0; v < 5; v++) begin
            run_train(vecs[v].amp, vecs[v].base,
                      vecs[v].d, vecs[v].h, vecs[v].l,
                      vecs[v].n, vecs[v].ext, vecs[v].dis,
                      first, donec);
            chk($sformatf("v%0d_first", v),
                first, vecs[v].exp_first);
            chk($sformatf("v%0d_done", v),
                donec, vecs[v].exp_done);
            repeat (2) tick();
        end

        ExtTrigEn = 1'b0;
        ExtTrig = 1'b1;
        tick();
        ExtTrig = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            tick();
            if (Busy) seen = 1'b1;
        end
        chk("ext_disabled", int'(seen), 0);

        Amplitude = 16'(300);
        Baseline = -16'sd1;
        DelayCycles = '0;
        HighCycles = 32'd1;
        LowCycles = 32'd1;
        PulseCount = 16'd1;
        SwTrig = 1'b1;
        tick();
        SwTrig = 1'b0;
        tick();
        chk("rt_high", int'(Dout), 300);
        SwTrig = 1'b1;
        tick();
        chk("rt_done", int'(Done), 1);
        chk("rt_busy0", int'(Busy), 0);
        chk("rt_base", int'(Dout), -1);
        SwTrig = 1'b0;
        tick();
        chk("rt_busy1", int'(Busy), 1);
        chk("rt_again", int'(Dout), 300);
        tick();
        chk("rt_done2", int'(Done), 1);
        prev_base = -1;
        prev_idx = 0;
        repeat (2) tick();

        for (int r = 0; r < 8; r++) begin
            amp  = int'($urandom_range(0, 2000)) - 1000;
            base = amp - int'($urandom_range(1, 500));
            run_train(amp, base,
                      int'($urandom_range(0, 4)),
                      int'($urandom_range(0, 4)),
                      int'($urandom_range(0, 4)),
                      int'($urandom_range(1, 4)),
                      1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)),
                      first, donec);
            repeat (int'($urandom_range(1, 3))) tick();
        end

        Amplitude = 16'(7);
        Baseline = -16'sd5;
        DelayCycles = '0;
        HighCycles = 32'd1;
        LowCycles = 32'd1;
        PulseCount = '0;
        SwTrig = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 1) SwTrig = 1'b0;
            if (k >= 2)
                chk("cont_dout", int'(Dout),
                    ((k - 2) % 2 == 0) ? 7 : -5);
        end
        chk("cont_idx", int'(PulseIdx), 4);
        Enable = 1'b0;
        tick();
        chk("abort_dout", int'(Dout), -5);
        chk("abort_busy", int'(Busy), 0);
        chk("abort_done", int'(Done), 0);
        seen = 1'b0;
        repeat (3) begin
            tick();
            if (Done || Busy) seen = 1'b1;
        end
        chk("abort_quiet", int'(seen), 0);
        Enable = 1'b1;
        tick();

        Amplitude = 16'(900);
        Baseline = 16'(100);
        HighCycles = 32'd3;
        LowCycles = 32'd2;
        PulseCount = 16'd3;
        c0 = cyc;
        SwTrig = 1'b1;
        repeat (6) tick();
        SwTrig = 1'b0;
        chk("pre_rst_busy", int'(Busy), 1);
        #2;
        Reset = 1'b0;
        #1;
        chk("mrst_dout", int'(Dout), 0);
        chk("mrst_busy", int'(Busy), 0);
        chk("mrst_idx", int'(PulseIdx), 0);
        chk("mrst_done", int'(Done), 0);
        #1;
        Reset = 1'b1;
        repeat (3) tick();
        chk("post_rst_busy", int'(Busy), 0);

        $display("[TB] %0d tests run, %0d failed",
                 tests, fails);
        $finish;
    end

endmodule
